sys_cmd_initiator: RTL
======================

Name: sys_cmd_initiator

Overview:
Host-side command initiator for the system-control byte protocol (frame opcodes AA/BB/CC/DD).
- Accepts one parallel command and serializes it into a UART-TX byte stream.
- Collects the 1- or 2-byte response from the UART-RX byte stream and returns it, with a timeout.
- Used in the host/bridge and as the active driver in system-level benches.

Parameters:
DATA_WIDTH, 8, byte/operand width
RF_ADDR, 4, register-file address width (zero-extended into the address byte)
TIMEOUT_CYC, 4096, max idle cycles between response bytes before abort (>=2)

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-low
CMD_VLD  in  1  command request
CMD_RDY  out  1  high only in IDLE; accept on CMD_VLD&&CMD_RDY
CMD_TYPE  in  2  00 write(AA), 01 read(BB), 10 ALU w/ operands(CC), 11 ALU no operands(DD)
CMD_ADDR  in  RF_ADDR  RF address (write/read)
CMD_WDATA  in  DATA_WIDTH  write data
CMD_OPA  in  DATA_WIDTH  operand A (CC)
CMD_OPB  in  DATA_WIDTH  operand B (CC)
CMD_FUN  in  4  ALU function (CC/DD)
TX_DATA  out  DATA_WIDTH  byte to UART transmitter
TX_VLD  out  1  byte valid; held with stable TX_DATA until TX_RDY
TX_RDY  in  1  transmitter accepts byte when TX_VLD&&TX_RDY
RX_DATA  in  DATA_WIDTH  byte from UART receiver
RX_VLD  in  1  single-cycle pulse per received byte
RSP_VLD  out  1  one-cycle completion pulse
RSP_DATA  out  2*DATA_WIDTH  response; byte0 in [7:0], byte1 in [15:8]
RSP_TIMEOUT  out  1  one-cycle abort pulse
BUSY  out  1  ~CMD_RDY

Behaviour:
- Reset: state IDLE; TX_DATA=0, TX_VLD=0, RSP_VLD=0, RSP_TIMEOUT=0, RSP_DATA=0; CMD_RDY=1 once RST deasserts; byte index, expected count and timeout counter =0.
- On accept, latch all CMD_* fields into a frame buffer and compute counts.
- Frame bytes / response count by type:
  - Write: AA, {0,ADDR}, WDATA; 0 response bytes.
  - Read: BB, {0,ADDR}; 1 response byte.
  - CC: CC, OPA, OPB, {0,FUN}; 2 response bytes if FUN in {0000,0010,1110}, else 1.
  - DD: DD, {0,FUN}; response count by the same FUN rule.
- States:
  - IDLE -> TX on accept.
  - TX: TX_VLD=1 and TX_DATA=frame[idx] from the cycle after accept. idx++ on each handshake. On the handshake of the last byte: go to RX_WAIT if response count>0, else DONE.
  - RX_WAIT: each RX_VLD stores RX_DATA into slot rx_idx, rx_idx++ and clears the timeout counter. Last expected byte -> DONE. Counter reaching TIMEOUT_CYC-1 with no RX_VLD that cycle -> ABORT.
  - DONE: RSP_VLD=1 for one cycle -> IDLE.
  - ABORT: RSP_TIMEOUT=1 for one cycle; RSP_DATA keeps any partial bytes -> IDLE.
- RSP_DATA is cleared on accept, updated only by stored bytes, and held until the next accept. Unused upper byte reads 0.
- Latency, with TX_RDY always 1:
  - First byte valid 1 cycle after accept.
  - One byte per cycle.
  - RSP_VLD 1 cycle after the last RX byte, or 1 cycle after the last TX handshake for a write.
- TX_RDY low: TX_VLD and TX_DATA hold with no change and no timeout counting. The timeout is active only in RX_WAIT.
- RX_VLD outside RX_WAIT, including the cycle of the final TX handshake, is discarded.
- CMD_VLD while busy is ignored; no queueing.
- RX_VLD coinciding with the timeout cycle: the byte wins and the counter clears.
- Reset mid-operation: all outputs drop immediately (asynchronously); the frame in progress is abandoned and no RSP pulse is emitted.

Decomposition:
- Shared package holds:
  - Opcode constants AA/BB/CC/DD.
  - CMD_TYPE encodings.
  - The two-byte ALU function set {0000,0010,1110}.
  - A function is_two_byte(fun), also used by the responder side.
- No sub-module; the timeout counter (width $clog2(TIMEOUT_CYC)) is inline.

Test Plan:
- Write, TYPE=00, ADDR=5, WDATA=3C, TX_RDY=1 -> TX bytes AA,05,3C on 3 consecutive cycles; RSP_VLD 1 cycle later; RSP_DATA=0000.
- Read, TYPE=01, ADDR=2 -> TX BB,02; then RX_VLD with 7E -> RSP_VLD next cycle, RSP_DATA=007E.
- CC with OPA=10, OPB=20, FUN=0 -> TX CC,10,20,00; RX 30 then 00 -> RSP_DATA=0030. The RSP_VLD pulse occurs only after the second byte.
- DD with FUN=1 -> TX DD,01; a single RX byte 05 -> RSP_VLD, RSP_DATA=0005.
- TX_RDY toggling 0/1 during a CC frame -> TX_DATA stable while stalled; no byte skipped or duplicated.
- Read with no response -> RSP_TIMEOUT exactly TIMEOUT_CYC cycles after entering RX_WAIT; CMD_RDY=1 the next cycle. Assert RST mid-TX -> TX_VLD=0 immediately, no RSP pulse.

Source files
------------

// File: rtl/sys_cmd_initiator_pkg.sv
// sys_cmd_initiator_pkg: opcodes, command encodings, FSM states and response-length rule
package sys_cmd_initiator_pkg;
  localparam logic [7:0] OP_WR     = 8'hAA;
  localparam logic [7:0] OP_RD     = 8'hBB;
  localparam logic [7:0] OP_ALU    = 8'hCC;
  localparam logic [7:0] OP_ALU_NO = 8'hDD;
  localparam logic [1:0] CMD_WR     = 2'b00;
  localparam logic [1:0] CMD_RD     = 2'b01;
  localparam logic [1:0] CMD_ALU    = 2'b10;
  localparam logic [1:0] CMD_ALU_NO = 2'b11;
  localparam logic [3:0] FUN_2B_A = 4'b0000;
  localparam logic [3:0] FUN_2B_B = 4'b0010;
  localparam logic [3:0] FUN_2B_C = 4'b1110;
  typedef enum logic [2:0] {S_IDLE, S_TX, S_RX_WAIT, S_DONE, S_ABORT} state_t;
  function automatic logic is_two_byte(input logic [3:0] fun);
    return fun inside {FUN_2B_A, FUN_2B_B, FUN_2B_C};
  endfunction
endpackage

// File: rtl/sys_cmd_initiator.sv
// sys_cmd_initiator: serializes one command into TX bytes and collects its 1/2-byte response with timeout
// Ports: CLK/RST (async, active-low); CMD_* command handshake; TX_* byte stream out (valid/ready);
// RX_* received byte pulses; RSP_VLD/RSP_DATA completion, RSP_TIMEOUT abort; BUSY = ~CMD_RDY.
module sys_cmd_initiator
  import sys_cmd_initiator_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int RF_ADDR     = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CMD_VLD,
  output logic                    CMD_RDY,
  input  logic [1:0]              CMD_TYPE,
  input  logic [RF_ADDR-1:0]      CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]   CMD_WDATA,
  input  logic [DATA_WIDTH-1:0]   CMD_OPA,
  input  logic [DATA_WIDTH-1:0]   CMD_OPB,
  input  logic [3:0]              CMD_FUN,
  output logic [DATA_WIDTH-1:0]   TX_DATA,
  output logic                    TX_VLD,
  input  logic                    TX_RDY,
  input  logic [DATA_WIDTH-1:0]   RX_DATA,
  input  logic                    RX_VLD,
  output logic                    RSP_VLD,
  output logic [2*DATA_WIDTH-1:0] RSP_DATA,
  output logic                    RSP_TIMEOUT,
  output logic                    BUSY
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  state_t state;
  logic [DATA_WIDTH-1:0] frame [4];
  logic [DATA_WIDTH-1:0] nf [4];
  logic [DATA_WIDTH-1:0] addr_b, fun_b;
  logic [1:0] idx, last, rsp_cnt, nlast, nrsp;
  logic rx_idx;
  logic [TW-1:0] tmo;
  assign CMD_RDY = state == S_IDLE;
  assign BUSY = ~CMD_RDY;
  assign addr_b = DATA_WIDTH'(CMD_ADDR);
  assign fun_b = DATA_WIDTH'(CMD_FUN);
  always_comb begin
    nf[0] = CMD_TYPE == CMD_WR ? DATA_WIDTH'(OP_WR) :
            CMD_TYPE == CMD_RD ? DATA_WIDTH'(OP_RD) :
            CMD_TYPE == CMD_ALU ? DATA_WIDTH'(OP_ALU) : DATA_WIDTH'(OP_ALU_NO);
    nf[1] = CMD_TYPE == CMD_ALU ? CMD_OPA : CMD_TYPE == CMD_ALU_NO ? fun_b : addr_b;
    nf[2] = CMD_TYPE == CMD_ALU ? CMD_OPB : CMD_WDATA;
    nf[3] = fun_b;
    nlast = CMD_TYPE == CMD_WR ? 2'd2 : CMD_TYPE == CMD_ALU ? 2'd3 : 2'd1;
    nrsp = CMD_TYPE == CMD_WR ? 2'd0 : CMD_TYPE == CMD_RD ? 2'd1 :
           is_two_byte(CMD_FUN) ? 2'd2 : 2'd1;
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state <= S_IDLE;
      frame <= '{default: '0};
      TX_DATA <= '0;
      TX_VLD <= 1'b0;
      RSP_VLD <= 1'b0;
      RSP_TIMEOUT <= 1'b0;
      RSP_DATA <= '0;
      idx <= '0;
      last <= '0;
      rsp_cnt <= '0;
      rx_idx <= 1'b0;
      tmo <= '0;
    end else begin
      RSP_VLD <= 1'b0;
      RSP_TIMEOUT <= 1'b0;
      case (state)
        S_IDLE: if (CMD_VLD) begin
          frame <= nf;
          last <= nlast;
          rsp_cnt <= nrsp;
          idx <= '0;
          rx_idx <= 1'b0;
          tmo <= '0;
          RSP_DATA <= '0;
          TX_DATA <= nf[0];
          TX_VLD <= 1'b1;
          state <= S_TX;
        end
        S_TX: if (TX_RDY) begin
          if (idx == last) begin
            TX_VLD <= 1'b0;
            state <= rsp_cnt == 2'd0 ? S_DONE : S_RX_WAIT;
            RSP_VLD <= rsp_cnt == 2'd0;
          end else begin
            idx <= idx + 2'd1;
            TX_DATA <= frame[idx + 2'd1];
          end
        end
        S_RX_WAIT: if (RX_VLD) begin
          // a byte arriving on the timeout cycle still counts and restarts the window
          tmo <= '0;
          rx_idx <= 1'b1;
          if (rx_idx) RSP_DATA[2*DATA_WIDTH-1:DATA_WIDTH] <= RX_DATA;
          else RSP_DATA[DATA_WIDTH-1:0] <= RX_DATA;
          if ({1'b0, rx_idx} == rsp_cnt - 2'd1) begin
            state <= S_DONE;
            RSP_VLD <= 1'b1;
          end
        end else if (tmo == TW'(TIMEOUT_CYC - 1)) begin
          state <= S_ABORT;
          RSP_TIMEOUT <= 1'b1;
        end else tmo <= tmo + TW'(1);
        default: state <= S_IDLE;
      endcase
    end
endmodule
